// File: rtl/panda_pkg.sv
// Shared types for the PANDA data-memory path: request/response records,
// requester identifiers and the arbiter port count.
package panda_pkg;

    localparam int unsigned DMEM_ARB_PORTS = 2;

    // Requester identity; the core LSU is port 0, the loader/debug master is port 1.
    typedef enum logic {
        PORT_LSU    = 1'b0,
        PORT_LOADER = 1'b1
    } dmem_port_e;

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

endpackage

// File: rtl/panda_data_mem_arbiter_if.sv
// Bus bundle between the data-memory requesters, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the surrounding system.
interface panda_data_mem_arbiter_if #(
    parameter int unsigned DataMemDepth = 32,
    parameter int unsigned NumPorts     = 2
);
    localparam int unsigned AW = $clog2(DataMemDepth);

    // Requester side
    logic [NumPorts-1:0]       req_i;
    logic [NumPorts-1:0][3:0]  we_i;
    logic [NumPorts-1:0][31:0] addr_i;
    logic [NumPorts-1:0][31:0] wdata_i;
    logic [NumPorts-1:0]       gnt_o;
    logic [NumPorts-1:0]       rvalid_o;
    logic [NumPorts-1:0][31:0] rdata_o;
    logic [NumPorts-1:0]       err_o;

    // RAM side
    logic                      mem_ce_o;
    logic [3:0]                mem_we_o;
    logic [AW-1:0]             mem_addr_o;
    logic [31:0]               mem_wdata_o;
    logic [31:0]               mem_rdata_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/panda_rr_arbiter.sv
// Two-way round-robin arbiter with one-hot grant.
// Only built when PANDA_DMEM_ARB_RR_EN is defined.
`ifdef PANDA_DMEM_ARB_RR_EN
module panda_rr_arbiter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       ptr_en_i,
    output logic [1:0] gnt_o
);
    // Port favoured on the next contention: the complement of the last
    // granted port, so the reset value of 0 lets the core win first.
    logic prio_q;

    // Contention goes to the favoured port; a lone request is granted as-is.
    always_comb begin
        gnt_o = '0;
        if (&req_i) begin
            gnt_o[prio_q] = 1'b1;
        end else begin
            gnt_o = req_i;
        end
    end

    // Pointer moves only when something was granted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else if (ptr_en_i) begin
            prio_q <= ~gnt_o[1];
        end
    end

endmodule
`endif

// File: rtl/panda_data_mem_arbiter.sv
// Shares the single-port data RAM between the core LSU (port 0) and the
// loader/debug master (port 1). Byte addresses become word addresses,
// out-of-range accesses are granted but never reach the RAM, and the
// response comes back one cycle after grant on the granted port.
// Define PANDA_DMEM_ARB_RR_EN for round-robin; otherwise port 0 has fixed priority.
module panda_data_mem_arbiter
    import panda_pkg::*;
#(
    parameter int unsigned DataMemDepth = 32,
    parameter int unsigned NumPorts     = DMEM_ARB_PORTS
) (
    input logic                     clk_i,
    input logic                     rst_i,
    panda_data_mem_arbiter_if.slave bus
);
    localparam int unsigned AW = $clog2(DataMemDepth);

    mem_req_t            req_s [NumPorts];
    mem_rsp_t            rsp   [NumPorts];
    logic [NumPorts-1:0] oor;
    logic [NumPorts-1:0] req_act;
    logic [NumPorts-1:0] gnt;
    logic                any_gnt;
    dmem_port_e          sel;

    logic                resp_valid_q;
    dmem_port_e          resp_port_q;
    logic                resp_err_q;
    logic                resp_rd_q;

    logic                addr_lsb_unused;

    // Gather each port's request and flag addresses beyond the RAM.
    always_comb begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
            req_s[p] = '{we: bus.we_i[p], addr: bus.addr_i[p], wdata: bus.wdata_i[p]};
            oor[p]   = |req_s[p].addr[31:AW+2];
        end
        addr_lsb_unused = ^{req_s[0].addr[1:0], req_s[1].addr[1:0]};
    end

    // No request is seen while reset is held, so nothing is granted.
    always_comb begin
        req_act = rst_i ? '0 : bus.req_i;
    end

`ifdef PANDA_DMEM_ARB_RR_EN
    panda_rr_arbiter u_rr_arbiter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_act),
        .ptr_en_i (any_gnt),
        .gnt_o    (gnt)
    );
`else
    // Fixed priority: the core always wins.
    always_comb begin
        gnt = {req_act[1] & ~req_act[0], req_act[0]};
    end
`endif

    // Grant summary and index of the winning port.
    always_comb begin
        any_gnt   = |gnt;
        sel       = dmem_port_e'(gnt[1]);
        bus.gnt_o = gnt;
    end

    // Drive the RAM from the granted in-range request; idle bus otherwise.
    always_comb begin
        bus.mem_ce_o    = 1'b0;
        bus.mem_we_o    = '0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (any_gnt && !oor[sel]) begin
            bus.mem_ce_o    = 1'b1;
            bus.mem_we_o    = req_s[sel].we;
            bus.mem_addr_o  = req_s[sel].addr[AW+1:2];
            bus.mem_wdata_o = req_s[sel].wdata;
        end
    end

    // Remember who was granted and how, for the response next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_port_q  <= PORT_LSU;
            resp_err_q   <= 1'b0;
            resp_rd_q    <= 1'b0;
        end else begin
            resp_valid_q <= any_gnt;
            if (any_gnt) begin
                resp_port_q <= sel;
                resp_err_q  <= oor[sel];
                resp_rd_q   <= (req_s[sel].we == 4'b0000);
            end
        end
    end

    // Route the response to the recorded port; reads of valid addresses carry RAM data.
    always_comb begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
            rsp[p] = '0;
            if (!rst_i && resp_valid_q && resp_port_q == dmem_port_e'(p[0])) begin
                rsp[p].rvalid = 1'b1;
                rsp[p].err    = resp_err_q;
                rsp[p].rdata  = (resp_err_q || !resp_rd_q) ? '0 : bus.mem_rdata_i;
            end
            bus.rvalid_o[p] = rsp[p].rvalid;
            bus.rdata_o[p]  = rsp[p].rdata;
            bus.err_o[p]    = rsp[p].err;
        end
    end

endmodule
